// File: rtl/cnv_win_gen.sv
// rtl/cnv_win_gen.sv - streaming zero-padded 3x3 window generator feeding the MAC array din bus
// Optional coordinate outputs (win_row_o/win_col_o) are enabled by defining CNV_WIN_COORD_EN.
module cnv_win_gen #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_i,
  input  logic        pix_vld_i,
  output logic        pix_rdy_o,
  output logic [71:0] win_o,
  output logic        win_vld_o,
  output logic        frame_done_o
`ifdef CNV_WIN_COORD_EN
  ,
  output logic [$clog2(HEIGHT)-1:0] win_row_o,
  output logic [$clog2(WIDTH)-1:0]  win_col_o
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [2:0] {
    S_FILL,
    S_RUN,
    S_EOL,
    S_FLUSH,
    S_FLUSH_EOL
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;

  // Tap array indexed [row][col][bit]; row 0 = top, col 0 = left. Flattened it is
  // exactly the window byte order (byte = row*3 + col).
  logic [2:0][2:0][7:0] tap_q, tap_d;

  logic [71:0] win_q, win_d;
  logic        win_vld_q, win_vld_d;
  logic        frame_done_q, frame_done_d;

  logic [7:0] lb0_q [0:WIDTH-1];
  logic [7:0] lb1_q [0:WIDTH-1];
  logic [7:0] lb0_rd, lb1_rd;
  logic       lb0_we, lb1_we;

  logic            accept;
  logic            shift_en;
  logic            tap_clr;
  logic            emit;
  logic [2:0][7:0] col_new;   // [0] top, [1] middle, [2] bottom

  // Ready is forced low while reset is held so no pixel is taken in the reset cycle.
  assign pix_rdy_o = !rst && (state_q == S_FILL || state_q == S_RUN);
  assign accept    = pix_vld_i && pix_rdy_o;

  // Both line buffers share the input column as their single read address.
  assign lb0_rd = lb0_q[in_col_q];
  assign lb1_rd = lb1_q[in_col_q];

  assign win_o        = win_q;
  assign win_vld_o    = win_vld_q;
  assign frame_done_o = frame_done_q;

  // Next-state, counter, tap-shift and window decode.
  always_comb begin
    state_d      = state_q;
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    tap_d        = tap_q;
    win_d        = win_q;
    win_vld_d    = 1'b0;
    frame_done_d = 1'b0;
    lb0_we       = 1'b0;
    lb1_we       = 1'b0;
    shift_en     = 1'b0;
    tap_clr      = 1'b0;
    emit         = 1'b0;
    col_new      = '0;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          lb1_we = 1'b1;
          if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = ROW_ONE;
            state_d  = S_RUN;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          shift_en = 1'b1;
          tap_clr  = (in_col_q == '0);
          emit     = (in_col_q != '0);
          // Row 1 must not see lb0: it still holds data from an earlier frame.
          col_new  = {pix_i, lb1_rd, (in_row_q == ROW_ONE) ? 8'd0 : lb0_rd};
          lb0_we   = 1'b1;
          lb1_we   = 1'b1;
          if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            state_d  = S_EOL;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
        end
      end
      S_EOL: begin
        shift_en = 1'b1;
        emit     = 1'b1;
        if (in_row_q == ROW_LAST) begin
          state_d = S_FLUSH;
        end else begin
          in_row_d = in_row_q + 1'b1;
          state_d  = S_RUN;
        end
      end
      S_FLUSH: begin
        shift_en = 1'b1;
        tap_clr  = (in_col_q == '0);
        emit     = (in_col_q != '0);
        col_new  = {8'd0, lb1_rd, lb0_rd};
        if (in_col_q == COL_LAST) begin
          in_col_d = '0;
          state_d  = S_FLUSH_EOL;
        end else begin
          in_col_d = in_col_q + 1'b1;
        end
      end
      S_FLUSH_EOL: begin
        shift_en = 1'b1;
        emit     = 1'b1;
        in_col_d = '0;
        in_row_d = '0;
        state_d  = S_FILL;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        tap_d[r][0] = tap_clr ? 8'd0 : tap_q[r][1];
        tap_d[r][1] = tap_clr ? 8'd0 : tap_q[r][2];
        tap_d[r][2] = col_new[r];
      end
    end

    if (emit) begin
      win_vld_d    = 1'b1;
      win_d        = tap_d;
      frame_done_d = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end
  end

  // State, counters, taps and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      in_col_q     <= '0;
      in_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      tap_q        <= '0;
      win_q        <= '0;
      win_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      tap_q        <= tap_d;
      win_q        <= win_d;
      win_vld_q    <= win_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers: the read above sees the old entry, so the shift uses pre-write data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (lb1_we) begin
        lb1_q[in_col_q] <= pix_i;
      end
      if (lb0_we) begin
        lb0_q[in_col_q] <= lb1_rd;
      end
    end
  end

`ifdef CNV_WIN_COORD_EN
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;

  assign win_row_o = win_row_q;
  assign win_col_o = win_col_q;

  // Centre coordinate of the window, loaded together with win_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (emit) begin
      win_row_q <= out_row_q;
      win_col_q <= out_col_q;
    end
  end
`endif

endmodule

// File: tb/tb_cnv_win_gen.sv
// tb/tb_cnv_win_gen.sv - self-checking bench for cnv_win_gen against a padded-frame window model
module tb_cnv_win_gen;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pix_i;
  logic        pix_vld_i;
  logic        pix_rdy_o;
  logic [71:0] win_o;
  logic        win_vld_o;
  logic        frame_done_o;
`ifdef CNV_WIN_COORD_EN
  logic [1:0]  win_row_o;
  logic [1:0]  win_col_o;
`endif

  cnv_win_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_i        (pix_i),
    .pix_vld_i    (pix_vld_i),
    .pix_rdy_o    (pix_rdy_o),
    .win_o        (win_o),
    .win_vld_o    (win_vld_o),
    .frame_done_o (frame_done_o)
`ifdef CNV_WIN_COORD_EN
    ,
    .win_row_o    (win_row_o),
    .win_col_o    (win_col_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    logic        last;
    int          r;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  logic [71:0] obs_q[$];
  int          fr [H][W];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt, win_cnt, rdy_low, done_cnt;
  int first_acc_cyc, acc6_cyc, first_win_cyc, done_cyc, done_rdy_low;
  logic last_acc;

  function automatic int px(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return fr[r][c];
  endfunction

  // Window centred on (r,c); byte k covers neighbour (r + k/3 - 1, c + k%3 - 1).
  function automatic logic [71:0] window(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[k*8 +: 8] = 8'(px(r + k / 3 - 1, c + k % 3 - 1));
    end
    return w;
  endfunction

  task automatic push_win(input int r, input int c);
    exp_t e;
    e.w = window(r, c);
    e.last = (r == H - 1) && (c == W - 1);
    e.r = r;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        push_win(r, c);
  endtask

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic clear_stats();
    acc_cnt = 0; win_cnt = 0; rdy_low = 0; done_cnt = 0;
    first_acc_cyc = -1; acc6_cyc = -1; first_win_cyc = -1;
    done_cyc = -1; done_rdy_low = -1;
    obs_q.delete();
  endtask

  // One clock: note ready/accept before the edge, then check registered outputs after it.
  task automatic tick();
    logic rdy, acc;
    int   cur;
    exp_t e;
    rdy = pix_rdy_o;
    acc = pix_vld_i && rdy;
    cur = cyc;
    if (!rdy) rdy_low++;
    if (acc) begin
      if (acc_cnt == 0) first_acc_cyc = cur;
      acc_cnt++;
      if (acc_cnt == 6) acc6_cyc = cur;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    if (win_vld_o) begin
      obs_q.push_back(win_o);
      if (win_cnt == 0) first_win_cyc = cur;
      win_cnt++;
      if (frame_done_o) begin
        done_cnt++;
        done_cyc = cur;
        done_rdy_low = rdy_low;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_window", {71'd0, win_vld_o}, 72'd0);
      end else begin
        e = exp_q.pop_front();
        check("win", win_o, e.w);
        check("frame_done", {71'd0, frame_done_o}, {71'd0, e.last});
`ifdef CNV_WIN_COORD_EN
        check("win_row", 72'(win_row_o), 72'(e.r));
        check("win_col", 72'(win_col_o), 72'(e.c));
`endif
      end
    end else begin
      check("done_without_window", {71'd0, frame_done_o}, 72'd0);
    end
    if (rdy && !acc) check("stall_no_window", {71'd0, win_vld_o}, 72'd0);
  endtask

  task automatic send(input int gap, input int n);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 400) begin
      pix_vld_i = ($urandom_range(99) >= gap);
      pix_i = pix_vld_i ? 8'(fr[idx / W][idx % W]) : 8'($urandom_range(255));
      tick();
      if (last_acc) idx++;
      guard++;
    end
    pix_vld_i = 1'b0;
    check("send_timeout", 72'(idx), 72'(n));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      pix_vld_i = $urandom_range(1);
      pix_i = 8'($urandom_range(255));
      tick();
      guard++;
    end
    pix_vld_i = 1'b0;
    check("drain_timeout", 72'(exp_q.size()), 72'd0);
  endtask

  task automatic ramp_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = 4 * r + c + 1;
  endtask

  initial begin
    rst = 1'b1;
    pix_vld_i = 1'b0;
    pix_i = 8'd0;
    clear_stats();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_rdy", {71'd0, pix_rdy_o}, 72'd0);
    check("rst_win", win_o, 72'd0);
    check("rst_vld", {71'd0, win_vld_o}, 72'd0);
    check("rst_done", {71'd0, frame_done_o}, 72'd0);
`ifdef CNV_WIN_COORD_EN
    check("rst_row", 72'(win_row_o), 72'd0);
    check("rst_col", 72'(win_col_o), 72'd0);
`endif
    rst = 1'b0;
    #1;
    check("rdy_after_rst", {71'd0, pix_rdy_o}, 72'd1);

    // Continuous ramp frame
    ramp_frame();
    clear_stats();
    push_frame();
    send(0, W * H);
    drain();
    check("first_win_const", obs_q[0], 72'h06_05_00_02_01_00_00_00_00);
    check("last_win_const", obs_q[11], 72'h00_00_00_00_0C_0B_00_08_07);
    check("win_count", 72'(win_cnt), 72'd12);
    check("first_win_latency", 72'(first_win_cyc), 72'(acc6_cyc));
    check("frame_cycles", 72'(done_cyc - first_acc_cyc + 1), 72'd19);
    check("rdy_low_cycles", 72'(done_rdy_low), 72'd7);

    // Ramp frame with random valid gaps
    clear_stats();
    push_frame();
    send(40, W * H);
    drain();
    check("stall_win_count", 72'(win_cnt), 72'd12);
    check("stall_first", obs_q[0], 72'h06_05_00_02_01_00_00_00_00);
    check("stall_last", obs_q[11], 72'h00_00_00_00_0C_0B_00_08_07);

    // Back-to-back: ramp then all-FF
    clear_stats();
    push_frame();
    send(0, W * H);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = 255;
    push_frame();
    send(0, W * H);
    drain();
    check("b2b_count", 72'(win_cnt), 72'd24);
    check("b2b_ff_first", obs_q[12], 72'hFF_FF_00_FF_FF_00_00_00_00);
    check("b2b_done_count", 72'(done_cnt), 72'd2);

    // Reset after 7 accepted pixels, then a clean frame
    ramp_frame();
    clear_stats();
    push_win(0, 0);
    push_win(0, 1);
    send(0, 7);
    rst = 1'b1;
    tick();
    check("abort_vld", {71'd0, win_vld_o}, 72'd0);
    check("abort_pending", 72'(exp_q.size()), 72'd0);
    rst = 1'b0;
    #1;
    push_frame();
    send(0, W * H);
    drain();
    check("abort_count", 72'(win_cnt), 72'd14);
    check("abort_restart_first", obs_q[2], 72'h06_05_00_02_01_00_00_00_00);
    check("abort_done_count", 72'(done_cnt), 72'd1);

    // Random-valued frames back to back with random gaps
    clear_stats();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          fr[r][c] = $urandom_range(255);
      push_frame();
      send(30, W * H);
    end
    drain();
    check("rand_count", 72'(win_cnt), 72'd24);
    check("rand_done_count", 72'(done_cnt), 72'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnv_win_gen.md
# cnv_win_gen

Streaming 3x3 window generator that sits directly upstream of the 16-MAC convolution array. It accepts a raster-order 8-bit pixel stream and holds two lines of the frame in line buffers. From these it emits one zero-padded 72-bit 3x3 window per output pixel, in raster order, on the shared `din` bus that feeds every MAC. This replaces per-pixel random access into a full frame memory.

## Interface
- `WIDTH`, default 128: frame width in pixels, ≥ 2.
- `HEIGHT`, default 128: frame height in pixels, ≥ 2.
- `clk`, input, 1: the single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `pix_i`, input, 8: input pixel, unsigned.
- `pix_vld_i`, input, 1: `pix_i` is valid.
- `pix_rdy_o`, output, 1: the block accepts a pixel when `pix_vld_i & pix_rdy_o`.
- `win_o`, output, 72: 3x3 window with 8 bits per tap.
  - Bytes 0/1/2 = top-left/top/top-right.
  - Bytes 3/4/5 = left/center/right.
  - Bytes 6/7/8 = bottom-left/bottom/bottom-right.
- `win_vld_o`, output, 1: `win_o` is valid. Single-cycle qualifier; there is no backpressure because the MACs always accept.
- `frame_done_o`, output, 1: one-cycle pulse, coincident with the last window of the frame.

## Operation
- Storage:
  - Two line buffers of WIDTH×8 bits: `lb1` holds row r-1 and `lb0` holds row r-2.
  - A 3-column × 3-row tap shift register.
  - An input counter `(in_row, in_col)` and an output counter `(out_row, out_col)`.
- FSM states: FILL, RUN, EOL, FLUSH, FLUSH_EOL.
- FILL:
  - `pix_rdy_o` = 1.
  - Accepts row 0 and writes it into `lb1`. No windows are produced.
  - After pixel (0, WIDTH-1) is accepted, go to RUN.
- RUN:
  - `pix_rdy_o` = 1.
  - For each accepted pixel (r, c), shift in the column {`lb0[c]` (zero when r = 1), `lb1[c]`, `pix_i`}. Then `lb0[c]` ← `lb1[c]` and `lb1[c]` ← `pix_i`.
  - For c ≥ 1, emit window (r-1, c-1). For c = 0, no output; the tap registers are cleared to zero before shifting, which gives left-edge padding.
  - After c = WIDTH-1, go to EOL.
- EOL:
  - `pix_rdy_o` = 0 for one cycle.
  - Shift in a zero column and emit window (r-1, WIDTH-1), which is the right-edge window.
  - Next state is RUN, or FLUSH if r was HEIGHT-1.
- FLUSH:
  - `pix_rdy_o` = 0 for WIDTH cycles.
  - Each cycle shifts the column {`lb0[k]`, `lb1[k]`, 0}, which gives bottom-edge padding.
  - Emits windows (HEIGHT-1, k-1) for k ≥ 1, then goes to FLUSH_EOL.
- FLUSH_EOL:
  - One cycle: shift a zero column and emit window (HEIGHT-1, WIDTH-1) with `frame_done_o` = 1.
  - Then go to FILL with counters cleared, ready for the next frame.
- Padding:
  - Row -1, row HEIGHT, column -1 and column WIDTH always read as 0.
  - Line-buffer contents from the previous frame are never visible; the top-row select forces zero.
- Exactly WIDTH×HEIGHT windows are emitted per frame, in raster order.
- `pix_vld_i` low in FILL or RUN stalls the block: no state change and no output.
- `pix_vld_i` is ignored in EOL, FLUSH and FLUSH_EOL.

## Timing
- Reset values: `pix_rdy_o` = 0 during the reset cycle and 1 in the first cycle after reset (state FILL). `win_o` = 0, `win_vld_o` = 0, `frame_done_o` = 0, and all counters are 0.
- `win_o` and `win_vld_o` are registered. A window triggered by an accept or a bubble cycle is visible in the following cycle.
- Latency:
  - Window (r, c) with c < WIDTH-1 appears 1 cycle after pixel (r+1, c+1) is accepted.
  - The right-edge window appears 1 cycle after the EOL cycle.
- With a continuous stream, a frame occupies WIDTH×HEIGHT + (HEIGHT-1) + WIDTH + 1 cycles. This comes from:
  - (HEIGHT-1) EOL bubbles;
  - WIDTH FLUSH cycles;
  - 1 FLUSH_EOL cycle.
- Reset mid-frame: `rst` takes effect in that cycle. The next cycle is in FILL and the partial frame is discarded. No `win_vld_o` or `frame_done_o` is asserted for it.
- Line-buffer read and write to the same address in one cycle is read-before-write: the old value is shifted in.

## Configuration
- `CNV_WIN_COORD_EN` defined:
  - Adds two outputs: `win_row_o` [$clog2(HEIGHT)-1:0] and `win_col_o` [$clog2(WIDTH)-1:0].
  - They are registered alongside `win_o` and carry the center coordinate of the current window.
  - Their reset value is 0.
- `CNV_WIN_COORD_EN` not defined: these ports and their registers are absent; all other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3, and pixel (r, c) = 4r + c + 1, streamed continuously unless stated otherwise.
- First window: first `win_vld_o` comes 1 cycle after pixel index 5 (value 6) is accepted, with `win_o` = 72'h06_05_00_02_01_00_00_00_00.
- Full frame:
  - Exactly 12 windows in raster order; the last one is 72'h00_00_00_00_0C_0B_00_08_07 with `frame_done_o` = 1.
  - Total frame time is 12 + 2 + 4 + 1 = 19 cycles.
  - `pix_rdy_o` is low exactly in the 2 EOL cycles and the 5 flush cycles.
- Stalls: random `pix_vld_i` gaps → the same 12 windows, bit-exact. `win_vld_o` = 0 during gaps in FILL/RUN.
- Back-to-back frames: a second frame of value 8'hFF starts immediately → its window (0,0) is 72'hFF_FF_00_FF_FF_00_00_00_00, with no leakage from frame 1.
- Reset mid-frame: assert `rst` after 7 accepted pixels, then restart the frame → window output matches the clean run, and there was no `frame_done_o` for the aborted frame.
- With `CNV_WIN_COORD_EN` defined: `(win_row_o, win_col_o)` sequences (0,0)…(2,3), aligned with `win_vld_o`.
